// File: rtl/can_mc_bus_master_if.sv
// can_mc_bus_master_if
//   Bundles the register-bus initiator's two handshakes and its chip-select bus.
//   Signal names keep the i_/o_ prefixes as seen from can_mc_bus_master.
//   Request  : i_req_valid, o_req_ready, i_req_addr[5:0], i_req_r_neg_w, i_req_wdata[31:0]
//   Response : o_rsp_valid, i_rsp_ready, o_rsp_rdata[31:0], o_rsp_error, o_rsp_timeout
//   Bus      : o_cs, o_r_neg_w, o_addr[5:0], o_bus_data[31:0], i_reg_data[31:0], i_ack, i_error
//   Modports : master = bus initiator (can_mc_bus_master)
//              slave  = everything around it (host command path plus responder)
interface can_mc_bus_master_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [5:0]  i_req_addr;
    logic        i_req_r_neg_w;
    logic [31:0] i_req_wdata;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_error;
    logic        o_rsp_timeout;

    logic        o_cs;
    logic        o_r_neg_w;
    logic [5:0]  o_addr;
    logic [31:0] o_bus_data;
    logic [31:0] i_reg_data;
    logic        i_ack;
    logic        i_error;

    modport master (
        input  i_req_valid, i_req_addr, i_req_r_neg_w, i_req_wdata,
        output o_req_ready,
        input  i_rsp_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_error, o_rsp_timeout,
        output o_cs, o_r_neg_w, o_addr, o_bus_data,
        input  i_reg_data, i_ack, i_error
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_r_neg_w, i_req_wdata,
        input  o_req_ready,
        output i_rsp_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_error, o_rsp_timeout,
        input  o_cs, o_r_neg_w, o_addr, o_bus_data,
        output i_reg_data, i_ack, i_error
    );
endinterface

// File: rtl/can_mc_bus_master.sv
// can_mc_bus_master
//   Bus initiator for the CAN controller's microcontroller register interface.
//   It takes one register read/write request at a time, runs a chip-select
//   bus cycle until the responder acks (or a timeout expires), and returns
//   the read data and status on a response handshake.
//
//   Ports:
//     i_sys_clk  - system clock
//     i_reset    - asynchronous, active-high reset
//     bus        - can_mc_bus_master_if.master (request, response, chip-select bus)
//
//   Parameters:
//     TIMEOUT_CYCLES - cycles o_cs stays high without i_ack before a timeout (2..255)
//     ADDR_MAX       - highest legal register address
//
//   Optional feature macro: CAN_MC_MASTER_RETRY_EN
//     When defined, the first timeout drops o_cs for one cycle (RETRY) and
//     re-runs the same bus cycle once; only a second timeout is reported.
//
//   Every output is a flop, so there is no combinational path from i_ack
//   (or any other input) to the bus or the response.
module can_mc_bus_master #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_MAX       = 30
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    can_mc_bus_master_if.master   bus
);

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] ADDR_MAX_L = 6'(ADDR_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RSP
`ifdef CAN_MC_MASTER_RETRY_EN
        , ST_RETRY
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        cs_q, cs_d;
    logic        r_neg_w_q, r_neg_w_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] bus_data_q, bus_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`ifdef CAN_MC_MASTER_RETRY_EN
    logic        retried_q, retried_d;
`endif

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            cs_q          <= 1'b0;
            r_neg_w_q     <= 1'b0;
            addr_q        <= '0;
            bus_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef CAN_MC_MASTER_RETRY_EN
            retried_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            cs_q          <= cs_d;
            r_neg_w_q     <= r_neg_w_d;
            addr_q        <= addr_d;
            bus_data_q    <= bus_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef CAN_MC_MASTER_RETRY_EN
            retried_q     <= retried_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        cs_d          = cs_q;
        r_neg_w_d     = r_neg_w_q;
        addr_d        = addr_q;
        bus_data_d    = bus_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef CAN_MC_MASTER_RETRY_EN
        retried_d     = retried_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Ready rises one cycle after reset release and after each
                // response handshake.
                req_ready_d = 1'b1;
                if (bus.i_req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (bus.i_req_addr > ADDR_MAX_L) begin
                        // Illegal address: answer straight away, bus registers
                        // keep their previous values since no cycle is run.
                        state_d       = ST_RSP;
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        // Bus registers are loaded only when a bus cycle starts,
                        // so they hold the last transaction's values otherwise.
                        state_d    = ST_BUS;
                        cs_d       = 1'b1;
                        cnt_d      = '0;
                        addr_d     = bus.i_req_addr;
                        r_neg_w_d  = bus.i_req_r_neg_w;
                        bus_data_d = bus.i_req_r_neg_w ? 32'd0 : bus.i_req_wdata;
`ifdef CAN_MC_MASTER_RETRY_EN
                        retried_d  = 1'b0;
`endif
                    end
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so it wins over a same-cycle timeout.
                if (bus.i_ack) begin
                    state_d       = ST_RSP;
                    cs_d          = 1'b0;
                    cnt_d         = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = bus.i_error;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (r_neg_w_q && !bus.i_error) ? bus.i_reg_data : 32'd0;
                end else if (cnt_q == TO_LAST) begin
                    cs_d  = 1'b0;
                    cnt_d = '0;
`ifdef CAN_MC_MASTER_RETRY_EN
                    if (!retried_q) begin
                        state_d   = ST_RETRY;
                        retried_d = 1'b1;
                    end else begin
                        state_d       = ST_RSP;
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                    end
`else
                    state_d       = ST_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
`endif
                end
            end

            ST_RSP: begin
                if (bus.i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

`ifdef CAN_MC_MASTER_RETRY_EN
            // One cs-low cycle so the responder drops its enables, then the
            // same captured request goes out again.
            ST_RETRY: begin
                state_d = ST_BUS;
                cs_d    = 1'b1;
                cnt_d   = '0;
            end
`endif

            default: begin
                state_d     = ST_IDLE;
                cs_d        = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    assign bus.o_req_ready   = req_ready_q;
    assign bus.o_cs          = cs_q;
    assign bus.o_r_neg_w     = r_neg_w_q;
    assign bus.o_addr        = addr_q;
    assign bus.o_bus_data    = bus_data_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;
    assign bus.o_rsp_error   = rsp_error_q;
    assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule
